// File: rtl/ir_key_ctrl.sv
// ir_key_ctrl
//   Key-command controller between the NEC IR receiver and the six-digit FND
//   display path. It validates each decoded frame and tracks key hold and
//   release from NEC repeat codes. It issues fresh-press and auto-repeat key
//   events and keeps a six-hex-digit entry buffer.
//
// Build option:
//   IR_KEY_ADDR_CHECK_EN - when defined, a frame is also rejected unless its
//                          address byte equals ADDR.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   i_frame      decoded frame {addr, ~addr, cmd, ~cmd}
//   i_frame_vld  one-cycle strobe qualifying i_frame
//   i_rpt_vld    one-cycle strobe for an NEC repeat code
//   o_key        last accepted command byte
//   o_key_vld    one-cycle key event strobe
//   o_key_rpt    1 when the current event is an auto-repeat
//   o_held       a key is currently held
//   o_digits     entry buffer, [3:0] is the rightmost digit
//   o_err_cnt    rejected-frame count, saturating at 8'hFF
module ir_key_ctrl #(
  parameter logic [7:0]  ADDR      = 8'h00,
  parameter logic [31:0] REL_CYC   = 32'd6_000_000,
  parameter logic [3:0]  RPT_START = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_rpt_vld,
  output logic [7:0]  o_key,
  output logic        o_key_vld,
  output logic        o_key_rpt,
  output logic        o_held,
  output logic [23:0] o_digits,
  output logic [7:0]  o_err_cnt
);

`ifdef IR_KEY_ADDR_CHECK_EN
  localparam logic ADDR_ANY = 1'b0;
`else
  localparam logic ADDR_ANY = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, HELD} state_t;

  state_t      state, state_nxt;
  logic [31:0] frame_p0, frame_nxt;
  logic [31:0] timer, timer_nxt;
  logic [3:0]  rpt_cnt, rpt_cnt_nxt;
  logic        rpt_exec_p1, rpt_exec_nxt;
  logic [7:0]  key_nxt;
  logic        key_vld_nxt, key_rpt_nxt, held_nxt;
  logic [23:0] digits_nxt;
  logic [7:0]  err_nxt;
  logic [7:0]  cmd;
  logic        frame_ok;

  function automatic logic [23:0] apply_cmd(input logic [23:0] d, input logic [7:0] c);
    if (c <= 8'h09)      return {d[19:0], c[3:0]};
    else if (c == 8'h0A) return 24'h000000;
    else if (c == 8'h0B) return {4'h0, d[23:4]};
    else                 return d;
  endfunction

  assign cmd = frame_p0[15:8];

  always_comb begin
    frame_ok = (frame_p0[15:8] == ~frame_p0[7:0]) &&
               (frame_p0[31:24] == ~frame_p0[23:16]) &&
               (ADDR_ANY || (frame_p0[31:24] == ADDR));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_frame_vld) state_nxt = CHECK;
      CHECK:   state_nxt = frame_ok ? EXEC : IDLE;
      EXEC:    state_nxt = HELD;
      HELD: begin
        if (i_frame_vld)      state_nxt = CHECK;
        else if (i_rpt_vld)   state_nxt = HELD;
        else if (timer == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    frame_nxt    = frame_p0;
    timer_nxt    = timer;
    rpt_cnt_nxt  = rpt_cnt;
    rpt_exec_nxt = 1'b0;
    key_nxt      = o_key;
    key_vld_nxt  = 1'b0;
    key_rpt_nxt  = 1'b0;
    digits_nxt   = o_digits;
    err_nxt      = o_err_cnt;

    // o_held survives CHECK/EXEC when a new frame interrupts a held key
    case (state_nxt)
      HELD:    held_nxt = 1'b1;
      IDLE:    held_nxt = 1'b0;
      default: held_nxt = o_held;
    endcase

    if (i_frame_vld && (state == IDLE || state == HELD))
      frame_nxt = i_frame;

    // A repeat accepted last cycle executes now, one cycle after the strobe
    if (rpt_exec_p1) begin
      key_nxt     = cmd;
      key_vld_nxt = 1'b1;
      key_rpt_nxt = 1'b1;
      digits_nxt  = apply_cmd(o_digits, cmd);
    end

    case (state)
      CHECK: begin
        if (!frame_ok && o_err_cnt != 8'hFF) err_nxt = o_err_cnt + 8'd1;
      end
      EXEC: begin
        key_nxt     = cmd;
        key_vld_nxt = 1'b1;
        digits_nxt  = apply_cmd(o_digits, cmd);
        timer_nxt   = REL_CYC;
        rpt_cnt_nxt = '0;
      end
      HELD: begin
        if (i_frame_vld) begin
          // frame wins; any simultaneous repeat is discarded
        end else if (i_rpt_vld) begin
          timer_nxt = REL_CYC;
          if (rpt_cnt != 4'hF) rpt_cnt_nxt = rpt_cnt + 4'd1;
          // the pending guard keeps o_key_vld from firing on back-to-back cycles
          if (rpt_cnt >= RPT_START && !rpt_exec_p1) rpt_exec_nxt = 1'b1;
        end else if (timer != '0) begin
          timer_nxt = timer - 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Output and control registers
  always_ff @(posedge clk) begin
    frame_p0 <= frame_nxt;
    if (rst) begin
      timer       <= '0;
      rpt_cnt     <= '0;
      rpt_exec_p1 <= 1'b0;
      o_key       <= 8'h00;
      o_key_vld   <= 1'b0;
      o_key_rpt   <= 1'b0;
      o_held      <= 1'b0;
      o_digits    <= 24'h000000;
      o_err_cnt   <= 8'h00;
    end else begin
      timer       <= timer_nxt;
      rpt_cnt     <= rpt_cnt_nxt;
      rpt_exec_p1 <= rpt_exec_nxt;
      o_key       <= key_nxt;
      o_key_vld   <= key_vld_nxt;
      o_key_rpt   <= key_rpt_nxt;
      o_held      <= held_nxt;
      o_digits    <= digits_nxt;
      o_err_cnt   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Testbench for ir_key_ctrl: directed stimulus with a key-event scoreboard.
module tb_ir_key_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_frame;
  logic        i_frame_vld;
  logic        i_rpt_vld;
  logic [7:0]  o_key;
  logic        o_key_vld;
  logic        o_key_rpt;
  logic        o_held;
  logic [23:0] o_digits;
  logic [7:0]  o_err_cnt;

  ir_key_ctrl #(
    .ADDR      (8'h00),
    .REL_CYC   (32'd100),
    .RPT_START (4'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_frame     (i_frame),
    .i_frame_vld (i_frame_vld),
    .i_rpt_vld   (i_rpt_vld),
    .o_key       (o_key),
    .o_key_vld   (o_key_vld),
    .o_key_rpt   (o_key_rpt),
    .o_held      (o_held),
    .o_digits    (o_digits),
    .o_err_cnt   (o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  key;
    logic        rpt;
    logic [23:0] digits;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] m_digits = '0;
  logic [7:0]  m_err = '0;
  logic [7:0]  m_cmd = '0;
  logic [3:0]  m_rpt = '0;
  logic        prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] model_apply(input logic [23:0] d, input logic [7:0] c);
    logic [23:0] r;
    r = d;
    if (c < 8'h0A)       r = (d << 4) | {20'h0, c[3:0]};
    else if (c == 8'h0A) r = '0;
    else if (c == 8'h0B) r = d >> 4;
    return r;
  endfunction

  // Event monitor: every o_key_vld pulse must match the oldest expectation
  always @(negedge clk) begin
    if (o_key_vld) begin
      chk("vld_gap", 32'(prev_vld), 32'd0);
      chk("evt_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_key", 32'(o_key), 32'(e.key));
        chk("evt_rpt", 32'(o_key_rpt), 32'(e.rpt));
        chk("evt_digits", 32'(o_digits), 32'(e.digits));
        chk("evt_cycle", 32'(cyc), 32'(e.due));
      end
    end
    prev_vld = o_key_vld;
  end

  task automatic press(input logic [31:0] f, input logic with_rpt, output int due);
    logic [7:0] c;
    logic ok;
    @(negedge clk);
    c  = f[15:8];
    ok = (c == ~f[7:0]) && (f[31:24] == ~f[23:16]);
`ifdef IR_KEY_ADDR_CHECK_EN
    ok = ok && (f[31:24] == 8'h00);
`endif
    due = cyc + 3;
    if (ok) begin
      m_digits = model_apply(m_digits, c);
      sb.push_back('{c, 1'b0, m_digits, due});
      m_cmd = c;
      m_rpt = '0;
    end else if (m_err != 8'hFF) begin
      m_err = m_err + 8'd1;
    end
    i_frame     = f;
    i_frame_vld = 1'b1;
    i_rpt_vld   = with_rpt;
    @(negedge clk);
    i_frame_vld = 1'b0;
    i_rpt_vld   = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_rpt();
    @(negedge clk);
    if (m_rpt >= 4'd2) begin
      m_digits = model_apply(m_digits, m_cmd);
      sb.push_back('{m_cmd, 1'b1, m_digits, cyc + 2});
    end
    if (m_rpt != 4'hF) m_rpt = m_rpt + 4'd1;
    i_rpt_vld = 1'b1;
    @(negedge clk);
    i_rpt_vld = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key"},    32'(o_key),     32'h00);
    chk({tag, "_vld"},    32'(o_key_vld), 32'd0);
    chk({tag, "_rpt"},    32'(o_key_rpt), 32'd0);
    chk({tag, "_held"},   32'(o_held),    32'd0);
    chk({tag, "_digits"}, 32'(o_digits),  32'h000000);
    chk({tag, "_err"},    32'(o_err_cnt), 32'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int due;
    rst = 1'b1; i_frame = '0; i_frame_vld = 1'b0; i_rpt_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // fresh presses 1, 2, 3
    press(32'h00FF_01FE, 1'b0, due);
    press(32'h00FF_02FD, 1'b0, due);
    press(32'h00FF_03FC, 1'b0, due);
    chk("digits_123", 32'(o_digits), 32'h000123);
    chk("err_zero", 32'(o_err_cnt), 32'h00);
    chk("held_after_press", 32'(o_held), 32'd1);

    // bad inverse command byte
    press(32'h00FF_05FB, 1'b0, due);
    chk("err_one", 32'(o_err_cnt), 32'h01);
    chk("digits_after_bad", 32'(o_digits), 32'h000123);

    // digit 7 then four repeats: events on the 3rd and 4th only
    press(32'h00FF_07F8, 1'b0, due);
    repeat (4) send_rpt();
    chk("digits_777", 32'(o_digits), 32'h123777);

    // release timing after a fresh press (clear)
    press(32'h00FF_0AF5, 1'b0, due);
    for (int k = 0; k < 200 && o_held; k++) @(negedge clk);
    chk("release_cycles", 32'(cyc - due), 32'd101);
    chk("digits_cleared", 32'(o_digits), 32'h000000);

    // buffer editing
    for (int d = 1; d <= 6; d++) begin
      logic [7:0] c;
      c = 8'(d);
      press({16'h00FF, c, ~c}, 1'b0, due);
    end
    chk("digits_123456", 32'(o_digits), 32'h123456);
    press(32'h00FF_0BF4, 1'b0, due);
    chk("backspace", 32'(o_digits), 32'h012345);
    press(32'h00FF_10EF, 1'b0, due);
    chk("other_cmd", 32'(o_digits), 32'h012345);
    press(32'h00FF_0AF5, 1'b0, due);
    chk("clear", 32'(o_digits), 32'h000000);

    // frame and repeat together once repeats would already fire
    press(32'h00FF_01FE, 1'b0, due);
    send_rpt();
    send_rpt();
    press(32'h00FF_02FD, 1'b1, due);
    chk("frame_wins", 32'(o_digits), 32'h000012);
    chk("frame_wins_rpt", 32'(o_key_rpt), 32'd0);

    // non-zero address
    press(32'h01FE_01FE, 1'b0, due);
`ifdef IR_KEY_ADDR_CHECK_EN
    chk("addr_digits", 32'(o_digits), 32'h000012);
    chk("addr_err", 32'(o_err_cnt), 32'h02);
`else
    chk("addr_digits", 32'(o_digits), 32'h000121);
    chk("addr_err", 32'(o_err_cnt), 32'h01);
`endif
    chk("model_digits", 32'(o_digits), 32'(m_digits));

    // reset while held
    press(32'h00FF_04FB, 1'b0, due);
    chk("held_before_rst", 32'(o_held), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_held");
    m_digits = '0; m_err = '0; m_rpt = '0;

    // error counter saturation
    for (int k = 0; k < 300; k++) press(32'h00FF_05FB, 1'b0, due);
    chk("err_sat", 32'(o_err_cnt), 32'hFF);
    chk("err_model", 32'(o_err_cnt), 32'(m_err));
    chk("digits_after_sat", 32'(o_digits), 32'h000000);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
